bcd_display_ctrl: RTL and testbench
===================================

# bcd_display_ctrl

Sequential binary-to-BCD controller that feeds the three-digit seven-segment display. It accepts a 10-bit binary count (0–999) over a valid/ready handshake and runs a one-bit-per-cycle double-dabble (shift-add-3) conversion. It then loads decimal digits into registered outputs that drive `SevenSeg`'s `digitL`/`digitM`/`digitR` inputs directly. This replaces divide/modulo-by-10 logic in the display path.

## Interface
- `IN_WIDTH`, 10: binary input width. Fixed at 10 for 3-digit output.
- `MAX_VALUE`, 999: clamp ceiling. Inputs above it saturate.
- `clk`  in  1: system clock. Single clock domain.
- `reset`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: `in_value` is presented for conversion.
- `in_value`  in  IN_WIDTH: binary value to display.
- `in_ready`  out  1: controller is idle and can accept a value.
- `digitL`  out  4: ones digit, BCD 0–9.
- `digitM`  out  4: tens digit, BCD 0–9.
- `digitR`  out  4: hundreds digit, BCD 0–9.
- `overflow`  out  1: last accepted value exceeded MAX_VALUE and was clamped.
- `done`  out  1: one-cycle pulse when the digit outputs update.

## Operation
- FSM states: IDLE, CONVERT, LOAD.
- Reset values:
  - state = IDLE.
  - `in_ready` = 1.
  - `digitL`/`digitM`/`digitR` = 0.
  - `overflow` = 0, `done` = 0.
  - Scratch registers and bit counter = 0.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid && in_ready`: latch `min(in_value, MAX_VALUE)` into the binary shift register and clear the 12-bit BCD scratch.
  - Latch the overflow flag as (`in_value > MAX_VALUE`).
  - Set bit counter to 0, go to CONVERT.
- CONVERT (`in_ready` = 0), once per cycle:
  - For each BCD nibble: if nibble ≥ 5, add 3.
  - Shift {BCD, binary} left 1 as a single 22-bit register.
  - Increment bit counter.
  - After the shift made with counter = IN_WIDTH−1 (10th shift), go to LOAD.
- LOAD (`in_ready` = 0):
  - Register BCD[3:0] → `digitL`, BCD[7:4] → `digitM`, BCD[11:8] → `digitR`.
  - Register the latched overflow flag → `overflow`.
  - Assert `done` for exactly this transition's following cycle.
  - Go to IDLE.
- Digit outputs hold their last loaded values at all times except reset. The display never shows intermediate conversion states.
- Width rules:
  - The add-3 is 4-bit and cannot carry out, because the nibble is ≤ 9 before adjust.
  - Clamping guarantees the hundreds nibble ≤ 9.
- Boundary conditions:
  - `in_valid` while busy is ignored. The value is not queued, and the producer must hold `in_valid` until `in_ready`.
  - `in_value` changes during CONVERT have no effect.
  - Reset mid-conversion aborts the conversion. All outputs return to reset values on the next edge, and no `done` is issued.
  - `in_value` = 0 still takes the full conversion latency.

## Timing
- Accept edge E0: `in_valid && in_ready` sampled high.
- Shifts occur on edges E1..E10.
- E11:
  - Digits and `overflow` update.
  - `done` = 1 for the cycle E11–E12.
  - `in_ready` returns to 1.
- Latency from accept to visible digits: 11 cycles.
- Earliest next accept: E12. With `in_valid` held high continuously, throughput is 1 conversion per 12 cycles.
- `in_ready` is a registered function of state, with no combinational path from `in_valid`.
- `done` and digit update are coincident. `done` is never asserted for 2 consecutive cycles.

## Test plan
- Reset, then idle 5 cycles → `in_ready`=1; `digitL`/`digitM`/`digitR`=0; `overflow`=0; `done`=0 throughout.
- Accept 537 at E0 → `in_ready` low E0–E11; at E11 R=5, M=3, L=7; `done` pulses once; `overflow`=0.
- Accept 0, then 999 → first yields 0/0/0 after 11 cycles; second yields 9/9/9; each `done` is a single pulse.
- Accept 1023 → digits 9/9/9 with `overflow`=1. A later accept of 42 → 0/4/2 with `overflow`=0.
- Hold `in_valid`=1 and change `in_value` from 123 to 456 at E5 → first result is 1/2/3. 456 is accepted at E12 and appears at E23.
- Accept 888, assert `reset` at E6 for 1 cycle → no `done`; all outputs = 0; `in_ready`=1 after the reset edge. A new accept of 7 → 0/0/7.

Source files
------------

// File: rtl/bcd_display_ctrl.sv
// Binary-to-BCD display controller: accepts a clamped 10-bit count and converts it with
// a one-bit-per-cycle shift-add-3 loop, then loads three BCD digits for the display.
module bcd_display_ctrl #(
  parameter int IN_WIDTH  = 10,
  parameter int MAX_VALUE = 999
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [IN_WIDTH-1:0] in_value,
  output logic                in_ready,
  output logic [3:0]          digitL,
  output logic [3:0]          digitM,
  output logic [3:0]          digitR,
  output logic                overflow,
  output logic                done
);

  localparam logic [IN_WIDTH-1:0] MAX_V    = IN_WIDTH'(MAX_VALUE);
  localparam logic [3:0]          LAST_BIT = 4'(IN_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    LOAD    = 2'd2
  } state_t;

  // A nibble of at most 9 becomes at most 12, so the 4-bit add cannot carry out.
  function automatic logic [3:0] add3_adjust(input logic [3:0] nib);
    logic [3:0] res;
    if (nib >= 4'd5) begin
      res = nib + 4'd3;
    end else begin
      res = nib;
    end
    return res;
  endfunction

  state_t              state_r;
  logic [IN_WIDTH-1:0] bin_r;
  logic [11:0]         bcd_r;
  logic [3:0]          bit_cnt_r;
  logic                ovf_latch_r;
  logic                in_ready_r;
  logic [3:0]          digit_l_r;
  logic [3:0]          digit_m_r;
  logic [3:0]          digit_r_r;
  logic                overflow_r;
  logic                done_r;

  logic [11:0]            bcd_adj_s;
  logic [IN_WIDTH+11:0]   shifted_s;
  logic [IN_WIDTH-1:0]    clamped_s;
  logic                   accept_s;

  // Next value of the combined {BCD, binary} shift register for one conversion step.
  always_comb begin
    bcd_adj_s = {add3_adjust(bcd_r[11:8]), add3_adjust(bcd_r[7:4]), add3_adjust(bcd_r[3:0])};
    shifted_s = {bcd_adj_s[10:0], bin_r, 1'b0};
  end

  // Input clamp and handshake qualification.
  always_comb begin
    accept_s = in_valid && in_ready_r;
    if (in_value > MAX_V) begin
      clamped_s = MAX_V;
    end else begin
      clamped_s = in_value;
    end
  end

  // Controller FSM; every output is a register so the display never sees scratch state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      bin_r       <= '0;
      bcd_r       <= 12'd0;
      bit_cnt_r   <= 4'd0;
      ovf_latch_r <= 1'b0;
      in_ready_r  <= 1'b1;
      digit_l_r   <= 4'd0;
      digit_m_r   <= 4'd0;
      digit_r_r   <= 4'd0;
      overflow_r  <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            bin_r       <= clamped_s;
            bcd_r       <= 12'd0;
            bit_cnt_r   <= 4'd0;
            ovf_latch_r <= (in_value > MAX_V);
            in_ready_r  <= 1'b0;
            state_r     <= CONVERT;
          end else begin
            in_ready_r <= 1'b1;
            state_r    <= IDLE;
          end
        end
        CONVERT: begin
          bcd_r      <= shifted_s[IN_WIDTH+11:IN_WIDTH];
          bin_r      <= shifted_s[IN_WIDTH-1:0];
          bit_cnt_r  <= bit_cnt_r + 4'd1;
          in_ready_r <= 1'b0;
          if (bit_cnt_r == LAST_BIT) begin
            state_r <= LOAD;
          end else begin
            state_r <= CONVERT;
          end
        end
        LOAD: begin
          digit_l_r  <= bcd_r[3:0];
          digit_m_r  <= bcd_r[7:4];
          digit_r_r  <= bcd_r[11:8];
          overflow_r <= ovf_latch_r;
          done_r     <= 1'b1;
          in_ready_r <= 1'b1;
          state_r    <= IDLE;
        end
        default: begin
          in_ready_r <= 1'b1;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign in_ready = in_ready_r;
  assign digitL   = digit_l_r;
  assign digitM   = digit_m_r;
  assign digitR   = digit_r_r;
  assign overflow = overflow_r;
  assign done     = done_r;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Directed bench for bcd_display_ctrl: hand-computed digits, handshake timing and reset abort.
module tb_bcd_display_ctrl;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [9:0] in_value;
  logic       in_ready;
  logic [3:0] digitL;
  logic [3:0] digitM;
  logic [3:0] digitR;
  logic       overflow;
  logic       done;

  int errors;
  int checks;

  logic [3:0] exp_l;
  logic [3:0] exp_m;
  logic [3:0] exp_r;
  logic       exp_ovf;

  bcd_display_ctrl #(.IN_WIDTH(10), .MAX_VALUE(999)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_value (in_value),
    .in_ready (in_ready),
    .digitL   (digitL),
    .digitM   (digitM),
    .digitR   (digitR),
    .overflow (overflow),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic [3:0] r, input logic [3:0] m,
                             input logic [3:0] l, input logic ovf);
    chk({tag, "_R"}, 32'(digitR), 32'(r));
    chk({tag, "_M"}, 32'(digitM), 32'(m));
    chk({tag, "_L"}, 32'(digitL), 32'(l));
    chk({tag, "_ovf"}, 32'(overflow), 32'(ovf));
  endtask

  // Accept v at E0, verify busy window E0..E11, result at E11 and single done pulse.
  task automatic run_conv(input string tag, input logic [9:0] v, input logic [3:0] r,
                          input logic [3:0] m, input logic [3:0] l, input logic ovf);
    @(negedge clk);
    in_valid = 1'b1;
    in_value = v;
    chk({tag, "_ready_pre"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_value = 10'd555;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      chk({tag, "_busy_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_busy_done"}, 32'(done), 32'd0);
      chk_outputs({tag, "_hold"}, exp_r, exp_m, exp_l, exp_ovf);
    end
    @(negedge clk);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_ready_post"}, 32'(in_ready), 32'd1);
    chk_outputs(tag, r, m, l, ovf);
    exp_r = r;
    exp_m = m;
    exp_l = l;
    exp_ovf = ovf;
    @(negedge clk);
    chk({tag, "_done_off"}, 32'(done), 32'd0);
    chk_outputs({tag, "_after"}, exp_r, exp_m, exp_l, exp_ovf);
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    exp_l    = 4'd0;
    exp_m    = 4'd0;
    exp_r    = 4'd0;
    exp_ovf  = 1'b0;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_value = 10'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_ready", 32'(in_ready), 32'd1);
      chk("idle_done", 32'(done), 32'd0);
      chk_outputs("idle", 4'd0, 4'd0, 4'd0, 1'b0);
    end

    run_conv("v537", 10'd537, 4'd5, 4'd3, 4'd7, 1'b0);
    run_conv("v0", 10'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    run_conv("v999", 10'd999, 4'd9, 4'd9, 4'd9, 1'b0);
    run_conv("v1023", 10'd1023, 4'd9, 4'd9, 4'd9, 1'b1);
    run_conv("v42", 10'd42, 4'd0, 4'd4, 4'd2, 1'b0);
    run_conv("v1000", 10'd1000, 4'd9, 4'd9, 4'd9, 1'b1);
    run_conv("v100", 10'd100, 4'd1, 4'd0, 4'd0, 1'b0);

    // in_valid held high; in_value changes mid-conversion and is picked up at E12.
    @(negedge clk);
    in_valid = 1'b1;
    in_value = 10'd123;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    in_value = 10'd456;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("hold_first_done", 32'(done), 32'd1);
    chk_outputs("hold_first", 4'd1, 4'd2, 4'd3, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("hold_second_busy", 32'(in_ready), 32'd0);
    chk("hold_second_done_off", 32'(done), 32'd0);
    chk_outputs("hold_mid", 4'd1, 4'd2, 4'd3, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("hold_second_early", 32'(done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("hold_second_done", 32'(done), 32'd1);
    chk_outputs("hold_second", 4'd4, 4'd5, 4'd6, 1'b0);
    @(negedge clk);
    chk("hold_second_done_off2", 32'(done), 32'd0);
    exp_r = 4'd4;
    exp_m = 4'd5;
    exp_l = 4'd6;
    exp_ovf = 1'b0;

    // Reset at E6 aborts a conversion of 888.
    @(negedge clk);
    in_valid = 1'b1;
    in_value = 10'd888;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk_outputs("rst", 4'd0, 4'd0, 4'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rst_no_done", 32'(done), 32'd0);
    end
    exp_r = 4'd0;
    exp_m = 4'd0;
    exp_l = 4'd0;
    exp_ovf = 1'b0;

    run_conv("v7", 10'd7, 4'd0, 4'd0, 4'd7, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
